// File: rtl/sigmoid_feeder.sv
// sigmoid_feeder: sequencing front-end for the FP sigmoid approximation unit.
// Accepts one tagged pre-activation at a time from a valid/ready stream and
// holds it on sig_x until the unit produces a result. The result is returned
// on a valid/ready output stream together with the tag, the exceptions and a
// timeout flag. Repeated inputs are answered from a one-entry result cache,
// because the unit only restarts when its input changes. A timeout bounds
// every wait on the unit.
//
// Ports:
//   clk, rst_l          clock, asynchronous active-low reset
//   round_mode          rounding mode, passed straight through to sig_round_mode
//   s_valid/s_ready     input handshake; s_data = x, s_tag = sideband tag
//   m_valid/m_ready     output handshake; m_data = sigmoid(x), m_tag,
//                       m_exceptions {invalid, infinite, overflow, underflow,
//                       inexact}, m_timeout
//   sig_x, sig_round_mode   drive the sigmoid unit
//   sig_out, sig_exceptions, sig_valid   sigmoid unit result
//   busy                operation in progress (state not IDLE)
//   timeout_count       saturating count of timeouts since reset
module sigmoid_feeder #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANT_WIDTH     = 24,
  parameter int TAG_W          = 4,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int W             = EXP_WIDTH + MANT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [2:0]       round_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic [4:0]       m_exceptions,
  output logic             m_timeout,
  output logic [W-1:0]     sig_x,
  output logic [2:0]       sig_round_mode,
  input  logic [W-1:0]     sig_out,
  input  logic [4:0]       sig_exceptions,
  input  logic             sig_valid,
  output logic             busy,
  output logic [7:0]       timeout_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OUT
  } state_t;

  localparam logic [EXP_WIDTH-1:0] EXP_HALF = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 2);
  // 0.5 = sigmoid(+0); matches the unit's own reset state.
  localparam logic [W-1:0] HALF_VAL = {1'b0, EXP_HALF, {(MANT_WIDTH-1){1'b0}}};
  localparam logic [W-1:0] QNAN_VAL = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-2){1'b0}}};
  localparam logic [3:0]   GUARD_INIT = 4'(GUARD_CYCLES);
  localparam logic [9:0]   TIMER_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       sig_x_q, sig_x_d;
  logic [W-1:0]       m_data_q, m_data_d;
  logic [TAG_W-1:0]   m_tag_q, m_tag_d;
  logic [4:0]         m_exc_q, m_exc_d;
  logic               m_timeout_q, m_timeout_d;
  logic [3:0]         guard_q, guard_d;
  logic [9:0]         timer_q, timer_d;
  logic [W-1:0]       cache_x_q, cache_x_d;
  logic [W-1:0]       cache_y_q, cache_y_d;
  logic [4:0]         cache_exc_q, cache_exc_d;
  logic               cache_ok_q, cache_ok_d;
  logic [7:0]         tcount_q, tcount_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      sig_x_q     <= '0;
      m_data_q    <= '0;
      m_tag_q     <= '0;
      m_exc_q     <= '0;
      m_timeout_q <= 1'b0;
      guard_q     <= '0;
      timer_q     <= '0;
      cache_x_q   <= '0;
      cache_y_q   <= HALF_VAL;
      cache_exc_q <= '0;
      cache_ok_q  <= 1'b1;
      tcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      sig_x_q     <= sig_x_d;
      m_data_q    <= m_data_d;
      m_tag_q     <= m_tag_d;
      m_exc_q     <= m_exc_d;
      m_timeout_q <= m_timeout_d;
      guard_q     <= guard_d;
      timer_q     <= timer_d;
      cache_x_q   <= cache_x_d;
      cache_y_q   <= cache_y_d;
      cache_exc_q <= cache_exc_d;
      cache_ok_q  <= cache_ok_d;
      tcount_q    <= tcount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sig_x_d     = sig_x_q;
    m_data_d    = m_data_q;
    m_tag_d     = m_tag_q;
    m_exc_d     = m_exc_q;
    m_timeout_d = m_timeout_q;
    guard_d     = guard_q;
    timer_d     = timer_q;
    cache_x_d   = cache_x_q;
    cache_y_d   = cache_y_q;
    cache_exc_d = cache_exc_q;
    cache_ok_d  = cache_ok_q;
    tcount_d    = tcount_q;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          m_tag_d = s_tag;
          if (cache_ok_q && (s_data == cache_x_q)) begin
            m_data_d    = cache_y_q;
            m_exc_d     = cache_exc_q;
            m_timeout_d = 1'b0;
            state_d     = ST_OUT;
          end else begin
            sig_x_d = s_data;
            guard_d = GUARD_INIT;
            timer_d = '0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        guard_d = (guard_q == '0) ? '0 : guard_q - 4'd1;
        timer_d = timer_q + 10'd1;
        // The guard window masks the stale out_valid left over from the
        // previous operation; capture takes priority over the timeout.
        if ((guard_q == '0) && sig_valid) begin
          m_data_d    = sig_out;
          m_exc_d     = sig_exceptions;
          m_timeout_d = 1'b0;
          cache_x_d   = sig_x_q;
          cache_y_d   = sig_out;
          cache_exc_d = sig_exceptions;
          cache_ok_d  = 1'b1;
          state_d     = ST_OUT;
        end else if (timer_q == TIMER_LAST) begin
          m_data_d    = QNAN_VAL;
          m_exc_d     = 5'b10000;
          m_timeout_d = 1'b1;
          // The unit may still be mid-computation for sig_x, so a later
          // identical input must relaunch rather than hit.
          cache_ok_d  = 1'b0;
          if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
          state_d     = ST_OUT;
        end
      end

      ST_OUT: begin
        if (m_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready        = (state_q == ST_IDLE);
  assign m_valid        = (state_q == ST_OUT);
  assign busy           = (state_q != ST_IDLE);
  assign m_data         = m_data_q;
  assign m_tag          = m_tag_q;
  assign m_exceptions   = m_exc_q;
  assign m_timeout      = m_timeout_q;
  assign sig_x          = sig_x_q;
  assign sig_round_mode = round_mode;
  assign timeout_count  = tcount_q;

endmodule

// File: tb/tb_sigmoid_feeder.sv
// Self-checking bench for sigmoid_feeder. A scheduled stub plays the sigmoid
// unit; expected results come from a transaction-level reference model of
// the result cache, guard window and timeout rules.
module tb_sigmoid_feeder;
  localparam int G = 2;
  localparam int T = 64;
  localparam logic [31:0] HALF = 32'h3F000000;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [2:0]  round_mode;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_tag;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_tag;
  logic [4:0]  m_exceptions;
  logic        m_timeout;
  logic [31:0] sig_x;
  logic [2:0]  sig_round_mode;
  logic [31:0] sig_out;
  logic [4:0]  sig_exceptions;
  logic        sig_valid;
  logic        busy;
  logic [7:0]  timeout_count;

  int errors = 0;
  int checks = 0;

  sigmoid_feeder #(
    .EXP_WIDTH(8), .MANT_WIDTH(24), .TAG_W(4),
    .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_l(rst_l), .round_mode(round_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .m_exceptions(m_exceptions), .m_timeout(m_timeout),
    .sig_x(sig_x), .sig_round_mode(sig_round_mode),
    .sig_out(sig_out), .sig_exceptions(sig_exceptions), .sig_valid(sig_valid),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mc_x, mc_y, mc_sx;
  logic [4:0]  mc_exc;
  bit          mc_ok;
  int          mc_tc;

  task automatic model_reset();
    mc_x = '0; mc_y = HALF; mc_exc = '0; mc_ok = 1'b1; mc_tc = 0; mc_sx = '0;
  endtask

  // Predicts the outcome of one sample given the cycles (relative to the
  // accept cycle) in which the stub raises sig_valid; -1 means no pulse.
  task automatic predict(input logic [31:0] x, input int p1, input int p2,
                         input logic [31:0] y, input logic [4:0] e,
                         output int lat, output logic [31:0] d,
                         output logic [4:0] ex, output logic to);
    int cap;
    if (mc_ok && x == mc_x) begin
      lat = 1; d = mc_y; ex = mc_exc; to = 1'b0;
    end else begin
      mc_sx = x;
      cap = -1;
      if (p1 >= G + 1 && p1 <= T) cap = p1;
      if (p2 >= G + 1 && p2 <= T && (cap < 0 || p2 < cap)) cap = p2;
      if (cap > 0) begin
        lat = cap + 1; d = y; ex = e; to = 1'b0;
        mc_x = x; mc_y = y; mc_exc = e; mc_ok = 1'b1;
      end else begin
        lat = T + 1; d = QNAN; ex = 5'b10000; to = 1'b1;
        mc_ok = 1'b0;
        if (mc_tc < 255) mc_tc++;
      end
    end
  endtask

  // Offers one sample and plays the sigmoid unit until m_valid rises (or the
  // cycle budget runs out, lat = -1). Leaves the result pending in OUT.
  task automatic run_txn(input logic [31:0] x, input logic [3:0] tag,
                         input int p1, input int p2,
                         input logic [31:0] y, input logic [4:0] e,
                         output int lat, output logic [31:0] od,
                         output logic [3:0] otag, output logic [4:0] oe,
                         output logic ot, output logic [31:0] osx);
    @(negedge clk);
    s_valid = 1'b1; s_data = x; s_tag = tag;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = $urandom; s_tag = 4'($urandom);
    lat = -1; osx = '0;
    for (int k = 1; k <= T + 8; k++) begin
      sig_valid      = (k == p1 || k == p2);
      sig_out        = sig_valid ? y : $urandom;
      sig_exceptions = sig_valid ? e : 5'($urandom);
      @(negedge clk);
      if (k == 1) osx = sig_x;
      if (m_valid) begin lat = k; break; end
      @(posedge clk); #1;
    end
    sig_valid = 1'b0;
    od = m_data; otag = m_tag; oe = m_exceptions; ot = m_timeout;
  endtask

  task automatic release_out();
    @(negedge clk); m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
  endtask

  // Shared per-transaction observation/expectation variables
  int          lat, xlat;
  logic [31:0] od, xd, osx;
  logic [3:0]  otag;
  logic [4:0]  oe, xe;
  logic        ot, xt;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid, busy, m_timeout} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got %b want 1000", {s_ready, m_valid, busy, m_timeout});
    end
    checks++;
    if (m_data !== '0 || m_tag !== '0 || m_exceptions !== '0) begin
      errors++; $display("FAIL reset_mout got %h/%h/%h want 0/0/0", m_data, m_tag, m_exceptions);
    end
    checks++;
    if (sig_x !== '0 || timeout_count !== '0) begin
      errors++; $display("FAIL reset_sig got sig_x=%h tc=%0d want 0/0", sig_x, timeout_count);
    end
    round_mode = 3'($urandom); #1;
    checks++;
    if (sig_round_mode !== round_mode) begin
      errors++; $display("FAIL round_mode got %b want %b", sig_round_mode, round_mode);
    end
  endtask

  task automatic test_reset_cache_hit();
    predict(32'h0, -1, -1, '0, '0, xlat, xd, xe, xt);
    run_txn(32'h0, 4'd3, -1, -1, 32'h0, 5'd0, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== 1 || od !== HALF || otag !== 4'd3 || osx !== '0) begin
      errors++; $display("FAIL reset_hit got lat=%0d d=%h tag=%0d sx=%h want 1/%h/3/0", lat, od, otag, osx, HALF);
    end
    release_out();
  endtask

  task automatic test_guard();
    predict(32'h40000000, 1, 6, 32'h3F6AAAAB, 5'b00001, xlat, xd, xe, xt);
    run_txn(32'h40000000, 4'd9, 1, 6, 32'h3F6AAAAB, 5'b00001, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== 7 || od !== 32'h3F6AAAAB || oe !== 5'b00001 || ot !== 1'b0) begin
      errors++; $display("FAIL guard_miss got lat=%0d d=%h e=%b t=%b want 7/3f6aaaab/00001/0", lat, od, oe, ot);
    end
    checks++;
    if (osx !== 32'h40000000 || otag !== 4'd9) begin
      errors++; $display("FAIL guard_launch got sx=%h tag=%0d want 40000000/9", osx, otag);
    end
    release_out();
    predict(32'h40000000, -1, -1, '0, '0, xlat, xd, xe, xt);
    run_txn(32'h40000000, 4'd2, -1, 2, 32'h11111111, 5'd0, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== 1 || od !== 32'h3F6AAAAB || oe !== 5'b00001 || otag !== 4'd2) begin
      errors++; $display("FAIL repeat_hit got lat=%0d d=%h e=%b tag=%0d want 1/3f6aaaab/00001/2", lat, od, oe, otag);
    end
    release_out();
  endtask

  task automatic test_timeout();
    predict(32'hC0800000, -1, -1, '0, '0, xlat, xd, xe, xt);
    run_txn(32'hC0800000, 4'd4, -1, -1, 32'h0, 5'd0, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== T + 1 || od !== QNAN || oe !== 5'b10000 || ot !== 1'b1) begin
      errors++; $display("FAIL timeout got lat=%0d d=%h e=%b t=%b want %0d/%h/10000/1", lat, od, oe, ot, T + 1, QNAN);
    end
    checks++;
    if (timeout_count !== 8'd1) begin
      errors++; $display("FAIL timeout_count got %0d want 1", timeout_count);
    end
    release_out();
    // Same x after a timeout must relaunch, not hit.
    predict(32'hC0800000, 3, -1, 32'h3C8F0000, 5'b00001, xlat, xd, xe, xt);
    run_txn(32'hC0800000, 4'd5, 3, -1, 32'h3C8F0000, 5'b00001, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== 4 || od !== 32'h3C8F0000 || ot !== 1'b0) begin
      errors++; $display("FAIL relaunch got lat=%0d d=%h t=%b want 4/3c8f0000/0", lat, od, ot);
    end
    release_out();
  endtask

  task automatic test_coincide();
    predict(32'h41200000, 2, T, 32'h3F7FFD00, 5'b00001, xlat, xd, xe, xt);
    run_txn(32'h41200000, 4'd6, 2, T, 32'h3F7FFD00, 5'b00001, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== T + 1 || od !== 32'h3F7FFD00 || ot !== 1'b0 || oe !== 5'b00001) begin
      errors++; $display("FAIL coincide got lat=%0d d=%h e=%b t=%b want %0d/3f7ffd00/00001/0", lat, od, oe, ot, T + 1);
    end
    checks++;
    if (timeout_count !== 8'(mc_tc)) begin
      errors++; $display("FAIL coincide_tc got %0d want %0d", timeout_count, mc_tc);
    end
    release_out();
  endtask

  task automatic test_stall();
    int bad;
    predict(32'h3E000000, 5, -1, 32'h3F07FFFF, 5'b00000, xlat, xd, xe, xt);
    run_txn(32'h3E000000, 4'd12, 5, -1, 32'h3F07FFFF, 5'b00000, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== xlat || od !== xd) begin
      errors++; $display("FAIL stall_result got lat=%0d d=%h want %0d/%h", lat, od, xlat, xd);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = $urandom; sig_valid = 1'($urandom);
      sig_out = $urandom; sig_exceptions = 5'($urandom);
      @(negedge clk);
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || m_data !== od ||
          m_tag !== otag || m_exceptions !== oe || m_timeout !== ot) bad++;
    end
    s_valid = 1'b0; sig_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [3];
    xs[0] = 32'h3F800000; xs[1] = 32'hBF800000; xs[2] = 32'h3F800000;
    for (int i = 0; i < 3; i++) begin
      predict(xs[i], 3 + i, -1, 32'h3F000000 + 32'(i + 1), 5'b00001, xlat, xd, xe, xt);
      run_txn(xs[i], 4'(5 + i), 3 + i, -1, 32'h3F000000 + 32'(i + 1), 5'b00001, lat, od, otag, oe, ot, osx);
      checks++;
      if (lat !== xlat || od !== xd || otag !== 4'(5 + i)) begin
        errors++; $display("FAIL b2b[%0d] got lat=%0d d=%h tag=%0d want %0d/%h/%0d", i, lat, od, otag, xlat, xd, 5 + i);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    logic [31:0] x, y;
    logic [4:0]  e;
    logic [3:0]  tag;
    int p1, p2;
    for (int i = 0; i < 4; i++) pool[i] = $urandom;
    for (int n = 0; n < 24; n++) begin
      x   = pool[$urandom_range(3, 0)];
      y   = $urandom;
      e   = 5'($urandom);
      tag = 4'($urandom);
      p1  = ($urandom_range(5, 0) == 0) ? -1 : int'($urandom_range(T + 3, 1));
      p2  = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(12, 1));
      predict(x, p1, p2, y, e, xlat, xd, xe, xt);
      run_txn(x, tag, p1, p2, y, e, lat, od, otag, oe, ot, osx);
      checks++;
      if (lat !== xlat || od !== xd || oe !== xe || ot !== xt || otag !== tag || osx !== mc_sx) begin
        errors++;
        $display("FAIL random[%0d] got lat=%0d d=%h e=%b t=%b tag=%0d sx=%h want %0d/%h/%b/%b/%0d/%h",
                 n, lat, od, oe, ot, otag, osx, xlat, xd, xe, xt, tag, mc_sx);
      end
      if (lat < 0) begin
        errors++; $display("FAIL random_budget got no m_valid want m_valid by cycle %0d", xlat);
      end
      repeat ($urandom_range(2, 0)) @(negedge clk);
      release_out();
    end
    checks++;
    if (timeout_count !== 8'(mc_tc)) begin
      errors++; $display("FAIL random_tc got %0d want %0d", timeout_count, mc_tc);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h12345678; s_tag = 4'd1;
    @(posedge clk); #1; s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, busy} !== 3'b100 || sig_x !== '0 || timeout_count !== '0) begin
      errors++; $display("FAIL midwait_reset got rdy/vld/busy=%b sx=%h tc=%0d want 100/0/0",
                         {s_ready, m_valid, busy}, sig_x, timeout_count);
    end
    @(negedge clk); rst_l = 1'b1;
    model_reset();
    predict(32'h0, -1, -1, '0, '0, xlat, xd, xe, xt);
    run_txn(32'h0, 4'd8, -1, -1, 32'h0, 5'd0, lat, od, otag, oe, ot, osx);
    checks++;
    if (lat !== 1 || od !== HALF || oe !== 5'b0 || ot !== 1'b0 || otag !== 4'd8) begin
      errors++; $display("FAIL midwait_cache got lat=%0d d=%h e=%b t=%b tag=%0d want 1/%h/0/0/8", lat, od, oe, ot, otag, HALF);
    end
    release_out();
  endtask

  initial begin
    rst_l = 1'b0; round_mode = 3'd0; s_valid = 1'b0; s_data = '0; s_tag = '0;
    m_ready = 1'b0; sig_out = '0; sig_exceptions = '0; sig_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    test_reset();
    test_reset_cache_hit();
    test_guard();
    test_timeout();
    test_coincide();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
